// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the MIPS IF stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] c_RESET_PC  = 32'h0040_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : IF stage; single-outstanding imem fetch feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_RESET_PC,
  parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic [31:0] Flush_PC_IN,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        WANT_FREEZE_IN,
  output logic        Imem_Req_OUT,
  output logic [31:0] Imem_Addr_OUT,
  input  logic        Imem_Valid_IN,
  input  logic [31:0] Imem_Data_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] Instr1_PC_Plus4_OUT,
  output logic        Fetch_Busy_OUT
);

  fetch_state_t r_state, w_state;
  logic [31:0]  r_pc_next, w_pc_next;
  logic [31:0]  r_req_pc, w_req_pc;
  logic         r_squash, w_squash;
  logic         r_redir_pend, w_redir_pend;
  logic [31:0]  r_redir_pc, w_redir_pc;
  logic [31:0]  r_instr, w_instr;
  logic [31:0]  r_pc, w_pc;
  logic [31:0]  r_pc4, w_pc4;

  logic [31:0]  w_alt_pc;
  logic [31:0]  w_flush_pc;
  logic [31:0]  w_fetch_pc;
  logic         w_deliver;
  logic         w_issue;

  assign w_alt_pc   = Alt_PC_IN & ~32'h3;
  assign w_flush_pc = Flush_PC_IN & ~32'h3;

  // A same-cycle redirect steers the issue itself, so only the request
  // already in flight survives as the delay slot.
  assign w_fetch_pc = Request_Alt_PC_IN ? w_alt_pc :
                      r_redir_pend      ? r_redir_pc : r_pc_next;

  assign w_deliver = (r_state == S_WAIT) && Imem_Valid_IN && !r_squash;
  assign w_issue   = !RESET && !FLUSH && !WANT_FREEZE_IN &&
                     ((r_state == S_ISSUE) || w_deliver);

  assign Imem_Req_OUT        = w_issue;
  assign Imem_Addr_OUT       = w_fetch_pc;
  assign Instr1_OUT          = r_instr;
  assign Instr1_PC_OUT       = r_pc;
  assign Instr1_PC_Plus4_OUT = r_pc4;
  assign Fetch_Busy_OUT      = (r_state == S_WAIT);

  always_comb begin
    w_state      = r_state;
    w_pc_next    = r_pc_next;
    w_req_pc     = r_req_pc;
    w_squash     = r_squash;
    w_redir_pend = r_redir_pend;
    w_redir_pc   = r_redir_pc;
    w_instr      = r_instr;
    w_pc         = r_pc;
    w_pc4        = r_pc4;

    if (FLUSH) begin
      w_instr      = NOP_INSTR;
      w_pc_next    = w_flush_pc;
      w_redir_pend = 1'b0;
      if ((r_state == S_WAIT) && !Imem_Valid_IN) begin
        w_squash = 1'b1;
      end else begin
        w_squash = 1'b0;
        w_state  = S_ISSUE;
      end
    end else begin
      if (Request_Alt_PC_IN && WANT_FREEZE_IN) begin
        w_redir_pend = 1'b1;
        w_redir_pc   = w_alt_pc;
      end else if (Request_Alt_PC_IN) begin
        w_pc_next    = w_alt_pc;
        w_redir_pend = 1'b0;
      end

      case (r_state)
        S_ISSUE: begin
          if (!WANT_FREEZE_IN) w_instr = NOP_INSTR;
        end
        S_WAIT: begin
          if (Imem_Valid_IN && r_squash) begin
            w_squash = 1'b0;
            w_instr  = NOP_INSTR;
            w_state  = S_ISSUE;
          end else if (Imem_Valid_IN) begin
            w_instr = Imem_Data_IN;
            w_pc    = r_req_pc;
            w_pc4   = r_req_pc + 32'd4;
            if (WANT_FREEZE_IN) w_state = S_HOLD;
          end else if (!WANT_FREEZE_IN) begin
            w_instr = NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (!WANT_FREEZE_IN) w_state = S_ISSUE;
        end
        default: w_state = S_ISSUE;
      endcase

      if (w_issue) begin
        w_req_pc     = w_fetch_pc;
        w_pc_next    = w_fetch_pc + 32'd4;
        w_redir_pend = 1'b0;
        w_state      = S_WAIT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_ISSUE;
      r_pc_next    <= RESET_PC;
      r_req_pc     <= 32'h0;
      r_squash     <= 1'b0;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= 32'h0;
      r_instr      <= NOP_INSTR;
      r_pc         <= 32'h0;
      r_pc4        <= 32'h0;
    end else begin
      r_state      <= w_state;
      r_pc_next    <= w_pc_next;
      r_req_pc     <= w_req_pc;
      r_squash     <= w_squash;
      r_redir_pend <= w_redir_pend;
      r_redir_pc   <= w_redir_pc;
      r_instr      <= w_instr;
      r_pc         <= w_pc;
      r_pc4        <= w_pc4;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed bench for fetch_unit with a variable-latency imem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic        FLUSH;
  logic [31:0] Flush_PC_IN;
  logic [31:0] Alt_PC_IN;
  logic        Request_Alt_PC_IN;
  logic        WANT_FREEZE_IN;
  logic        Imem_Req_OUT;
  logic [31:0] Imem_Addr_OUT;
  logic        Imem_Valid_IN = 1'b0;
  logic [31:0] Imem_Data_IN  = 32'h0;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr1_PC_OUT;
  logic [31:0] Instr1_PC_Plus4_OUT;
  logic        Fetch_Busy_OUT;

  int total = 0;
  int bad   = 0;
  int lat   = 1;

  fetch_unit dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .FLUSH               (FLUSH),
    .Flush_PC_IN         (Flush_PC_IN),
    .Alt_PC_IN           (Alt_PC_IN),
    .Request_Alt_PC_IN   (Request_Alt_PC_IN),
    .WANT_FREEZE_IN      (WANT_FREEZE_IN),
    .Imem_Req_OUT        (Imem_Req_OUT),
    .Imem_Addr_OUT       (Imem_Addr_OUT),
    .Imem_Valid_IN       (Imem_Valid_IN),
    .Imem_Data_IN        (Imem_Data_IN),
    .Instr1_OUT          (Instr1_OUT),
    .Instr1_PC_OUT       (Instr1_PC_OUT),
    .Instr1_PC_Plus4_OUT (Instr1_PC_Plus4_OUT),
    .Fetch_Busy_OUT      (Fetch_Busy_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] tg(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  // Instruction memory: returns tg(addr) exactly lat cycles after a request.
  logic        s_req;
  logic [31:0] s_addr;
  logic        m_pend = 1'b0;
  logic [31:0] m_addr = 32'h0;
  int          m_cnt  = 0;
  always begin
    @(negedge CLK);
    s_req  = Imem_Req_OUT;
    s_addr = Imem_Addr_OUT;
    @(posedge CLK);
    #1;
    Imem_Valid_IN = 1'b0;
    if (m_pend) begin
      if (m_cnt == 1) begin
        Imem_Valid_IN = 1'b1;
        Imem_Data_IN  = tg(m_addr);
        m_pend        = 1'b0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    if (s_req) begin
      if (lat == 1) begin
        Imem_Valid_IN = 1'b1;
        Imem_Data_IN  = tg(s_addr);
      end else begin
        m_addr = s_addr;
        m_cnt  = lat - 1;
        m_pend = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] pc4);
    chk({tag, "_instr"}, Instr1_OUT, ins);
    chk({tag, "_pc"}, Instr1_PC_OUT, pc);
    chk({tag, "_pc4"}, Instr1_PC_Plus4_OUT, pc4);
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; Flush_PC_IN = 32'h0; Alt_PC_IN = 32'h0;
    Request_Alt_PC_IN = 1'b0; WANT_FREEZE_IN = 1'b0;
    cyc(); cyc();
    chk_dec("reset", 32'h0, 32'h0, 32'h0);
    chk("reset_busy", Fetch_Busy_OUT, 1'b0);
    RESET = 1'b0; #1;
    chk("first_req", Imem_Req_OUT, 1'b1);
    chk("first_addr", Imem_Addr_OUT, 32'h0040_0000);

    cyc(); // first fetch outstanding: decode sees NOP
    chk_dec("first_nop", 32'h0, 32'h0, 32'h0);
    chk("first_busy", Fetch_Busy_OUT, 1'b1);
    #1 chk("b2b_addr", Imem_Addr_OUT, 32'h0040_0004);
    cyc(); chk_dec("seq0", tg(32'h0040_0000), 32'h0040_0000, 32'h0040_0004);
    cyc(); chk_dec("seq1", tg(32'h0040_0004), 32'h0040_0004, 32'h0040_0008);

    // 0x00400008 is in flight; redirect with unaligned target
    Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h0040_0101; #1;
    chk("redir_req", Imem_Req_OUT, 1'b1);
    chk("redir_addr", Imem_Addr_OUT, 32'h0040_0100);
    cyc(); Request_Alt_PC_IN = 1'b0; Alt_PC_IN = 32'h0;
    chk_dec("delay_slot", tg(32'h0040_0008), 32'h0040_0008, 32'h0040_000C);
    cyc(); chk_dec("target0", tg(32'h0040_0100), 32'h0040_0100, 32'h0040_0104);
    cyc(); chk_dec("target1", tg(32'h0040_0104), 32'h0040_0104, 32'h0040_0108);

    // freeze for 4 cycles while 0x00400108 returns; redirect mid-freeze
    WANT_FREEZE_IN = 1'b1; #1 chk("frz_noreq0", Imem_Req_OUT, 1'b0);
    cyc(); chk_dec("frz_cap", tg(32'h0040_0108), 32'h0040_0108, 32'h0040_010C);
    Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h0040_0200;
    #1 chk("frz_noreq1", Imem_Req_OUT, 1'b0);
    cyc(); Request_Alt_PC_IN = 1'b0; Alt_PC_IN = 32'h0;
    chk_dec("frz_hold1", tg(32'h0040_0108), 32'h0040_0108, 32'h0040_010C);
    #1 chk("frz_noreq2", Imem_Req_OUT, 1'b0);
    cyc(); chk_dec("frz_hold2", tg(32'h0040_0108), 32'h0040_0108, 32'h0040_010C);
    #1 chk("frz_noreq3", Imem_Req_OUT, 1'b0);
    cyc(); chk_dec("frz_hold3", tg(32'h0040_0108), 32'h0040_0108, 32'h0040_010C);
    WANT_FREEZE_IN = 1'b0; #1 chk("unfrz_noreq", Imem_Req_OUT, 1'b0);
    cyc(); chk_dec("unfrz_hold", tg(32'h0040_0108), 32'h0040_0108, 32'h0040_010C);
    #1 chk("pend_req", Imem_Req_OUT, 1'b1);
    chk("pend_addr", Imem_Addr_OUT, 32'h0040_0200);
    cyc(); chk_dec("pend_nop", 32'h0, 32'h0040_0108, 32'h0040_010C);
    cyc(); chk_dec("pend_tgt", tg(32'h0040_0200), 32'h0040_0200, 32'h0040_0204);

    // latency 3 starting with the fetch of 0x00400208
    lat = 3;
    cyc(); chk_dec("l3_prev", tg(32'h0040_0204), 32'h0040_0204, 32'h0040_0208);
    #1 chk("l3_noreq0", Imem_Req_OUT, 1'b0);
    cyc(); chk_dec("l3_nop0", 32'h0, 32'h0040_0204, 32'h0040_0208);
    chk("l3_busy", Fetch_Busy_OUT, 1'b1);
    #1 chk("l3_noreq1", Imem_Req_OUT, 1'b0);
    cyc(); chk_dec("l3_nop1", 32'h0, 32'h0040_0204, 32'h0040_0208);
    cyc(); chk_dec("l3_data", tg(32'h0040_0208), 32'h0040_0208, 32'h0040_020C);

    // flush while 0x0040020C is outstanding
    cyc(); chk_dec("fl_pre", 32'h0, 32'h0040_0208, 32'h0040_020C);
    FLUSH = 1'b1; Flush_PC_IN = 32'h0040_0043; #1;
    chk("fl_noreq", Imem_Req_OUT, 1'b0);
    cyc(); FLUSH = 1'b0; Flush_PC_IN = 32'h0;
    chk("fl_nop", Instr1_OUT, 32'h0);
    chk("fl_busy", Fetch_Busy_OUT, 1'b1);
    #1 chk("fl_drop_noreq", Imem_Req_OUT, 1'b0);
    cyc(); chk_dec("fl_dropped", 32'h0, 32'h0040_0208, 32'h0040_020C);
    chk("fl_idle", Fetch_Busy_OUT, 1'b0);
    lat = 1; #1;
    chk("fl_req", Imem_Req_OUT, 1'b1);
    chk("fl_addr", Imem_Addr_OUT, 32'h0040_0040);
    cyc(); chk("fl_nop2", Instr1_OUT, 32'h0);
    lat = 3;
    cyc(); chk_dec("fl_tgt", tg(32'h0040_0040), 32'h0040_0040, 32'h0040_0044);

    // reset in S_WAIT; the old response arrives the cycle after
    cyc(); chk("rw_busy", Fetch_Busy_OUT, 1'b1);
    RESET = 1'b1; #1 chk("rw_noreq", Imem_Req_OUT, 1'b0);
    cyc(); chk_dec("rw_reset", 32'h0, 32'h0, 32'h0);
    chk("rw_idle", Fetch_Busy_OUT, 1'b0);
    RESET = 1'b0; #1;
    chk("rw_req", Imem_Req_OUT, 1'b1);
    chk("rw_addr", Imem_Addr_OUT, 32'h0040_0000);
    cyc(); chk("rw_stale_nop", Instr1_OUT, 32'h0);
    cyc(); chk_dec("rw_wait1", 32'h0, 32'h0, 32'h0);
    cyc(); chk_dec("rw_wait2", 32'h0, 32'h0, 32'h0);
    cyc(); chk_dec("rw_first", tg(32'h0040_0000), 32'h0040_0000, 32'h0040_0004);

    // wrap-around: redirect to the top word while 0x00400004 is pending
    Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'hFFFF_FFFE; lat = 1;
    cyc(); Request_Alt_PC_IN = 1'b0; Alt_PC_IN = 32'h0;
    chk("wr_nop0", Instr1_OUT, 32'h0);
    cyc(); chk("wr_nop1", Instr1_OUT, 32'h0);
    #1 chk("wr_addr_top", Imem_Addr_OUT, 32'hFFFF_FFFC);
    cyc(); chk_dec("wr_slot", tg(32'h0040_0004), 32'h0040_0004, 32'h0040_0008);
    #1 chk("wr_addr_zero", Imem_Addr_OUT, 32'h0);
    cyc(); chk_dec("wr_top", tg(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
